// File: rtl/fmc_cap_pkg.sv
// Shared encodings for the FMC capture buffer: FSM state codes and
// bit positions inside the cfg_ctrl and stat_word register words.
package fmc_cap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } cap_state_t;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_SLOPE = 2;
  localparam int CTRL_FORCE = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_TRIG    = 1;
  localparam int STAT_DONE    = 2;
  localparam int STAT_CODE_LO = 3;
  localparam int STAT_CODE_HI = 5;

endpackage

// File: rtl/cap_dpram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port.
// Contents are never reset so a finished capture survives a reset.
module cap_dpram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Write the incoming sample and register the read word one cycle later.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fmc_capture_buf.sv
// Triggered ADC capture buffer. STM32 arms it through the cfg registers; it
// records a pre/post-trigger window into RAM, then STM32 reads the window
// back by logical index (0 = oldest sample) through rd_data.
module fmc_capture_buf #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [15:0]       cfg_ctrl,
  input  logic [15:0]       cfg_level,
  input  logic [15:0]       cfg_decim,
  input  logic [15:0]       cfg_pretrig,
  input  logic [15:0]       cfg_rd_addr,
  output logic [15:0]       stat_word,
  output logic [15:0]       rd_data,
  output logic [15:0]       trig_pos
);
  import fmc_cap_pkg::*;

  cap_state_t        state, state_nx;
  logic              arm_q;
  logic [15:0]       dec_cnt;
  logic [15:0]       decim_r;
  logic [DATA_W-1:0] level_r;
  logic [DATA_W-1:0] prev_r;
  logic              slope_r;
  logic              prev_valid;
  logic              triggered_r;
  logic [ADDR_W-1:0] pre_r;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] trig_pos_r;
  logic [ADDR_W-1:0] phys_q;
  logic [ADDR_W:0]   cnt, cnt_nx;
  logic [15:0]       stat_q, stat_nx;
  logic              rd_ok;
  logic [DATA_W-1:0] ram_q;

  logic              arm_edge;
  logic              abort;
  logic              force_trig;
  logic              accepted;
  logic              edge_hit;
  logic              arm_go;
  logic              wr_en;
  logic              trig_fire;
  logic [ADDR_W-1:0] pre_clamped;
  logic [ADDR_W:0]   post_total;
  logic              unused_cfg;

  assign arm_edge    = cfg_ctrl[CTRL_ARM] & ~arm_q;
  assign abort       = cfg_ctrl[CTRL_ABORT];
  assign force_trig  = cfg_ctrl[CTRL_FORCE];
  assign accepted    = adc_valid && (dec_cnt == 16'd0);
  assign pre_clamped = (cfg_pretrig >= 16'(DEPTH - 1)) ? ADDR_W'(DEPTH - 1)
                                                       : cfg_pretrig[ADDR_W-1:0];
  assign post_total  = (ADDR_W+1)'(DEPTH) - {1'b0, pre_r};
  assign edge_hit    = slope_r ? (prev_r >= level_r && adc_data <  level_r)
                               : (prev_r <  level_r && adc_data >= level_r);
  assign unused_cfg  = ^{cfg_ctrl[15:4], cfg_level[15:DATA_W], cfg_rd_addr[15:ADDR_W]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, RAM write strobe and the PRE/POST sample counter.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wr_en     = 1'b0;
    trig_fire = 1'b0;
    arm_go    = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm_edge) begin
            arm_go   = 1'b1;
            cnt_nx   = '0;
            state_nx = (pre_clamped == '0) ? ST_WAIT : ST_PRE;
          end
        end
        ST_PRE: begin
          if (accepted) begin
            wr_en  = 1'b1;
            cnt_nx = cnt + 1'b1;
            if (cnt_nx == {1'b0, pre_r}) begin
              state_nx = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (accepted) begin
            wr_en = 1'b1;
            if (force_trig || (prev_valid && edge_hit)) begin
              trig_fire = 1'b1;
              cnt_nx    = (ADDR_W+1)'(1);
              state_nx  = ST_POST;
            end
          end
        end
        ST_POST: begin
          if (cnt == post_total) begin
            state_nx = ST_DONE;
          end else if (accepted) begin
            wr_en  = 1'b1;
            cnt_nx = cnt + 1'b1;
            if (cnt_nx == post_total) begin
              state_nx = ST_DONE;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Capture datapath: config latch at arm, decimation, write pointer, trigger record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_q       <= 1'b0;
      cnt         <= '0;
      wp          <= '0;
      dec_cnt     <= '0;
      decim_r     <= '0;
      level_r     <= '0;
      slope_r     <= 1'b0;
      pre_r       <= '0;
      prev_r      <= '0;
      prev_valid  <= 1'b0;
      trig_pos_r  <= '0;
      triggered_r <= 1'b0;
    end else begin
      arm_q <= cfg_ctrl[CTRL_ARM];
      cnt   <= cnt_nx;
      if (arm_go) begin
        level_r     <= cfg_level[DATA_W-1:0];
        slope_r     <= cfg_ctrl[CTRL_SLOPE];
        decim_r     <= cfg_decim;
        pre_r       <= pre_clamped;
        wp          <= '0;
        dec_cnt     <= '0;
        prev_valid  <= 1'b0;
        triggered_r <= 1'b0;
      end else begin
        if (adc_valid) begin
          dec_cnt <= (dec_cnt >= decim_r) ? 16'd0 : dec_cnt + 16'd1;
        end
        if (wr_en) begin
          wp         <= wp + 1'b1;
          prev_r     <= adc_data;
          prev_valid <= 1'b1;
        end
        if (trig_fire) begin
          trig_pos_r  <= wp;
          triggered_r <= 1'b1;
        end
        if (abort) begin
          triggered_r <= 1'b0;
        end
      end
    end
  end

  // Status word contents derived from the current state.
  always_comb begin
    stat_nx                                = '0;
    stat_nx[STAT_BUSY]                     = (state == ST_PRE) || (state == ST_WAIT) ||
                                             (state == ST_POST);
    stat_nx[STAT_TRIG]                     = triggered_r;
    stat_nx[STAT_DONE]                     = (state == ST_DONE);
    stat_nx[STAT_CODE_HI:STAT_CODE_LO]     = state;
  end

  // Status is registered so it trails the state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_nx;
    end
  end

  // Logical-to-physical read address, rotated so index 0 is the oldest sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phys_q <= '0;
      rd_ok  <= 1'b0;
    end else begin
      phys_q <= (trig_pos_r - pre_r) + cfg_rd_addr[ADDR_W-1:0];
      rd_ok  <= 1'b1;
    end
  end

  cap_dpram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wp),
    .wr_data(adc_data),
    .rd_addr(phys_q),
    .rd_data(ram_q)
  );

  assign stat_word = stat_q;
  assign trig_pos  = 16'(trig_pos_r);
  assign rd_data   = rd_ok ? 16'(ram_q) : 16'd0;

endmodule

// File: tb/tb_fmc_capture_buf.sv
// Bench for fmc_capture_buf with a 16-deep buffer: directed capture scenarios
// plus randomized captures compared against a window model built from the
// list of samples fed since the arm edge.
module tb_fmc_capture_buf;
  import fmc_cap_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 12;
  localparam logic [15:0] DONE_WORD = 16'h0026;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic [15:0]       cfg_ctrl;
  logic [15:0]       cfg_level;
  logic [15:0]       cfg_decim;
  logic [15:0]       cfg_pretrig;
  logic [15:0]       cfg_rd_addr;
  logic [15:0]       stat_word;
  logic [15:0]       rd_data;
  logic [15:0]       trig_pos;

  int total;
  int bad;
  int vals[$];
  int exp_win[DEPTH];
  int exp_tpos;
  bit exp_found;
  int data_mode;
  int ramp_val;

  fmc_capture_buf #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .cfg_ctrl   (cfg_ctrl),
    .cfg_level  (cfg_level),
    .cfg_decim  (cfg_decim),
    .cfg_pretrig(cfg_pretrig),
    .cfg_rd_addr(cfg_rd_addr),
    .stat_word  (stat_word),
    .rd_data    (rd_data),
    .trig_pos   (trig_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int d, input bit v);
    adc_data  = DATA_W'(d);
    adc_valid = v;
    tick();
    if (v) vals.push_back(d);
  endtask

  task automatic feed_one();
    int d;
    bit v;
    v = 1'b1;
    case (data_mode)
      0: begin d = ramp_val; ramp_val++; end
      1: begin d = ramp_val; ramp_val--; end
      2: begin
        d = int'($urandom_range(63, 0));
        v = ($urandom_range(3, 0) != 0);
      end
      default: d = 7;
    endcase
    applyStimulus(d, v);
  endtask

  task automatic arm_capture(input int decim, input int pre, input int level, input bit slope);
    cfg_decim   = 16'(decim);
    cfg_pretrig = 16'(pre);
    cfg_level   = 16'(level);
    cfg_ctrl    = 16'h0000;
    cfg_ctrl[CTRL_SLOPE] = slope;
    adc_valid   = 1'b0;
    tick();
    cfg_ctrl[CTRL_ARM] = 1'b1;
    tick();
    vals.delete();
  endtask

  task automatic feed_until(input int code, input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      feed_one();
      if (int'(stat_word[STAT_CODE_HI:STAT_CODE_LO]) == code) hit = 1'b1;
    end
    checkOutput(tag, 16'(hit), 16'd1);
  endtask

  task automatic read_idx(input int k, output logic [15:0] d);
    cfg_rd_addr = 16'(k);
    tick();
    tick();
    d = rd_data;
  endtask

  // Expected window: accepted samples are every (decim+1)-th valid sample;
  // logical index k of the capture is accepted sample (t - pre + k).
  task automatic model_capture(input int decim, input int pre, input int level, input bit slope);
    int acc[$];
    int p;
    int t;
    int idx;
    bit hit;
    foreach (vals[i]) if (i % (decim + 1) == 0) acc.push_back(vals[i]);
    p = (pre > DEPTH - 1) ? DEPTH - 1 : pre;
    exp_found = 1'b0;
    t = 0;
    for (int i = (p > 0 ? p : 1); i < acc.size(); i++) begin
      hit = slope ? (acc[i-1] >= level && acc[i] < level)
                  : (acc[i-1] < level && acc[i] >= level);
      if (hit && !exp_found) begin
        exp_found = 1'b1;
        t = i;
      end
    end
    exp_tpos = t % DEPTH;
    for (int k = 0; k < DEPTH; k++) begin
      idx = t - p + k;
      exp_win[k] = (exp_found && idx < acc.size()) ? acc[idx] : -1;
    end
  endtask

  task automatic check_capture(input string tag, input int decim, input int pre,
                               input int level, input bit slope);
    logic [15:0] d;
    adc_valid = 1'b0;
    model_capture(decim, pre, level, slope);
    checkOutput({tag, "_found"}, 16'(exp_found), 16'd1);
    checkOutput({tag, "_stat"}, stat_word, DONE_WORD);
    checkOutput({tag, "_tpos"}, trig_pos, 16'(exp_tpos));
    for (int k = 0; k < DEPTH; k++) begin
      read_idx(k + 16 * int'($urandom_range(15, 0)), d);
      checkOutput($sformatf("%s_idx%0d", tag, k), d, 16'(exp_win[k]));
    end
  endtask

  initial begin
    logic [15:0] d;
    int decim, pre, level, fpos;
    bit slope;

    total = 0; bad = 0;
    rst = 1'b0; adc_data = '0; adc_valid = 1'b0;
    cfg_ctrl = '0; cfg_level = '0; cfg_decim = '0; cfg_pretrig = '0; cfg_rd_addr = '0;
    data_mode = 0; ramp_val = 0;

    // Power-on reset
    #12;
    checkOutput("reset_stat", stat_word, 16'd0);
    checkOutput("reset_rd", rd_data, 16'd0);
    checkOutput("reset_tpos", trig_pos, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();
    checkOutput("idle_after_reset", stat_word, 16'd0);

    // Rising ramp, pre=4, level=20
    data_mode = 0; ramp_val = 0;
    arm_capture(0, 4, 20, 1'b0);
    feed_until(int'(ST_DONE), 200, "ramp_done");
    check_capture("ramp", 0, 4, 20, 1'b0);
    checkOutput("ramp_tpos_c", trig_pos, 16'd4);
    read_idx(0, d);  checkOutput("ramp_idx0_c", d, 16'd16);
    read_idx(4, d);  checkOutput("ramp_idx4_c", d, 16'd20);
    read_idx(15, d); checkOutput("ramp_idx15_c", d, 16'd31);

    // Decimated ramp, keep every third sample
    data_mode = 0; ramp_val = 0;
    arm_capture(2, 2, 30, 1'b0);
    feed_until(int'(ST_DONE), 300, "decim_done");
    check_capture("decim", 2, 2, 30, 1'b0);
    checkOutput("decim_tpos_c", trig_pos, 16'd10);
    read_idx(0, d);  checkOutput("decim_idx0_c", d, 16'd24);
    read_idx(1, d);  checkOutput("decim_idx1_c", d, 16'd27);
    read_idx(2, d);  checkOutput("decim_idx2_c", d, 16'd30);
    read_idx(15, d); checkOutput("decim_idx15_c", d, 16'd69);

    // Falling ramp, pre=0
    data_mode = 1; ramp_val = 40;
    arm_capture(0, 0, 25, 1'b1);
    feed_until(int'(ST_DONE), 200, "fall_done");
    check_capture("fall", 0, 0, 25, 1'b1);
    checkOutput("fall_tpos_c", trig_pos, 16'd0);
    read_idx(0, d);  checkOutput("fall_idx0_c", d, 16'd24);
    read_idx(15, d); checkOutput("fall_idx15_c", d, 16'd9);

    // Abort in WAIT, then arm and abort together
    data_mode = 0; ramp_val = 0;
    arm_capture(0, 2, 1000, 1'b0);
    feed_until(int'(ST_WAIT), 50, "abort_reach_wait");
    cfg_ctrl[CTRL_ABORT] = 1'b1;
    adc_valid = 1'b0;
    tick(); tick();
    checkOutput("abort_wait_stat", stat_word, 16'd0);
    cfg_ctrl = '0;
    tick();
    cfg_ctrl[CTRL_ARM] = 1'b1;
    cfg_ctrl[CTRL_ABORT] = 1'b1;
    tick(); tick(); tick();
    checkOutput("arm_abort_stat", stat_word, 16'd0);
    cfg_ctrl = '0;
    tick();

    // Abort after the trigger clears the triggered bit
    data_mode = 0; ramp_val = 0;
    arm_capture(0, 2, 20, 1'b0);
    feed_until(int'(ST_POST), 100, "abort_reach_post");
    cfg_ctrl[CTRL_ABORT] = 1'b1;
    adc_valid = 1'b0;
    tick(); tick();
    checkOutput("abort_post_stat", stat_word, 16'd0);
    cfg_ctrl = '0;
    tick();

    // Arm edge during POST is ignored
    data_mode = 0; ramp_val = 0;
    arm_capture(0, 2, 20, 1'b0);
    feed_until(int'(ST_POST), 100, "rearm_reach_post");
    cfg_ctrl[CTRL_ARM] = 1'b0;
    feed_one();
    cfg_ctrl[CTRL_ARM] = 1'b1;
    feed_one();
    feed_one();
    checkOutput("rearm_still_post", 16'(stat_word[STAT_CODE_HI:STAT_CODE_LO]), 16'd3);
    feed_until(int'(ST_DONE), 100, "rearm_done");
    check_capture("rearm", 0, 2, 20, 1'b0);

    // Reset mid-POST clears outputs immediately; stays idle until an arm edge
    data_mode = 0; ramp_val = 0;
    arm_capture(0, 4, 20, 1'b0);
    feed_until(int'(ST_POST), 100, "rst_reach_post");
    #2;
    rst = 1'b0;
    cfg_ctrl = '0;
    #1;
    checkOutput("midrst_stat", stat_word, 16'd0);
    checkOutput("midrst_rd", rd_data, 16'd0);
    checkOutput("midrst_tpos", trig_pos, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 5; n++) feed_one();
    checkOutput("midrst_idle", stat_word, 16'd0);
    adc_valid = 1'b0;
    cfg_ctrl[CTRL_ARM] = 1'b1;
    tick(); tick();
    checkOutput("midrst_rearm", stat_word, 16'h0009);
    cfg_ctrl = '0;
    cfg_ctrl[CTRL_ABORT] = 1'b1;
    tick(); tick();
    cfg_ctrl = '0;
    tick();

    // Forced trigger on constant input with an oversized pre-trigger count
    data_mode = 3;
    arm_capture(0, 100, 4095, 1'b0);
    feed_until(int'(ST_WAIT), 100, "force_reach_wait");
    fpos = vals.size() % DEPTH;
    cfg_ctrl[CTRL_FORCE] = 1'b1;
    feed_until(int'(ST_DONE), 10, "force_done");
    adc_valid = 1'b0;
    checkOutput("force_tpos", trig_pos, 16'(fpos));
    checkOutput("force_stat", stat_word, DONE_WORD);
    for (int k = 0; k < DEPTH; k++) begin
      read_idx(k, d);
      checkOutput($sformatf("force_idx%0d", k), d, 16'd7);
    end
    cfg_ctrl = '0;
    tick();

    // Randomized captures
    for (int r = 0; r < 6; r++) begin
      data_mode = 2;
      decim = int'($urandom_range(3, 0));
      pre   = int'($urandom_range(20, 0));
      level = int'($urandom_range(47, 16));
      slope = 1'($urandom_range(1, 0));
      arm_capture(decim, pre, level, slope);
      feed_until(int'(ST_DONE), 1500, $sformatf("rnd%0d_done", r));
      check_capture($sformatf("rnd%0d", r), decim, pre, level, slope);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
